// File: rtl/ts_capture.sv
// Two-channel pulse period capture with saturation, timeout and valid strobes.
// Optional 2-flop input synchronizer selected by macro TS_SYNC_EN.
//
// ts_chan ports:
//   clk, rst       clock, synchronous active-high reset
//   pin            pulse input
//   ts, vld, stale last period, update strobe, timeout level
// ts_capture ports:
//   clk, rst       clock, synchronous active-high reset
//   in1, in2       pulse inputs
//   ts1, ts2       last periods, saturated to 2^W-1
//   vld1, vld2     one-cycle update strobes
//   stale1, stale2 timeout levels
// Build options:
//   TS_SYNC_EN     2-flop synchronizer per input (async inputs allowed)

module ts_chan #(
  parameter int W     = 8,
  parameter int MIN_P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pin,
  output logic [W-1:0] ts,
  output logic         vld,
  output logic         stale
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    STALE
  } state_t;

  localparam logic [W-1:0] MAXV = {W{1'b1}};
  localparam logic [W-1:0] MINV = W'(MIN_P);
  localparam logic [W-1:0] ONE  = W'(1);

`ifdef TS_SYNC_EN
  logic meta_q, meta_d;
`endif
  logic         sync_q, sync_d;
  logic         prev_q, prev_d;
  logic         edge_det;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ts_q, ts_d;
  logic         vld_q, vld_d;
  logic         stale_q, stale_d;
  logic [W-1:0] cnt_inc;

  always_comb begin
`ifdef TS_SYNC_EN
    meta_d = pin;
    sync_d = meta_q;
`else
    sync_d = pin;
`endif
    prev_d   = sync_q;
    edge_det = sync_q & ~prev_q;

    cnt_inc  = (cnt_q == MAXV) ? MAXV : cnt_q + ONE;

    state_d  = state_q;
    cnt_d    = cnt_inc;
    ts_d     = ts_q;
    vld_d    = 1'b0;
    stale_d  = stale_q;

    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = ARMED;
          cnt_d   = ONE;
        end
      end
      ARMED: begin
        // Edges too close to the last accepted one are
        // dropped; the count keeps running across them.
        if (edge_det && (cnt_q >= MINV)) begin
          ts_d  = cnt_q;
          vld_d = 1'b1;
          cnt_d = ONE;
        end else if (cnt_q == MAXV) begin
          ts_d    = MAXV;
          vld_d   = 1'b1;
          stale_d = 1'b1;
          state_d = STALE;
        end
      end
      STALE: begin
        cnt_d = MAXV;
        if (edge_det) begin
          state_d = ARMED;
          cnt_d   = ONE;
          stale_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef TS_SYNC_EN
      meta_q  <= 1'b0;
`endif
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ts_q    <= '0;
      vld_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
`ifdef TS_SYNC_EN
      meta_q  <= meta_d;
`endif
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      vld_q   <= vld_d;
      stale_q <= stale_d;
    end
  end

  assign ts    = ts_q;
  assign vld   = vld_q;
  assign stale = stale_q;

endmodule

module ts_capture #(
  parameter int W     = 8,
  parameter int MIN_P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in1,
  input  logic         in2,
  output logic [W-1:0] ts1,
  output logic [W-1:0] ts2,
  output logic         vld1,
  output logic         vld2,
  output logic         stale1,
  output logic         stale2
);

  ts_chan #(
    .W     (W),
    .MIN_P (MIN_P)
  ) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .pin   (in1),
    .ts    (ts1),
    .vld   (vld1),
    .stale (stale1)
  );

  ts_chan #(
    .W     (W),
    .MIN_P (MIN_P)
  ) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .pin   (in2),
    .ts    (ts2),
    .vld   (vld2),
    .stale (stale2)
  );

endmodule

// File: tb/tb_ts_capture.sv
// Randomized bench for ts_capture against an event-level period model.
// Honors TS_SYNC_EN for the expected input-to-output latency.

module tb_ts_capture;

  localparam int W     = 8;
  localparam int MIN_P = 3;
  localparam int MAXV  = (1 << W) - 1;
`ifdef TS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic         in1;
  logic         in2;
  logic [W-1:0] ts1;
  logic [W-1:0] ts2;
  logic         vld1;
  logic         vld2;
  logic         stale1;
  logic         stale2;

  ts_capture #(
    .W     (W),
    .MIN_P (MIN_P)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .ts1    (ts1),
    .ts2    (ts2),
    .vld1   (vld1),
    .vld2   (vld2),
    .stale1 (stale1),
    .stale2 (stale2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ts;
    bit vld;
    bit stale;
  } out_t;

  int   n_chk;
  int   n_fail;

  // Model state: sample index, last accepted rise per channel.
  int   n;
  bit   armed [2];
  bit   stl   [2];
  int   last  [2];
  int   tsm   [2];
  bit   prv   [2];
  out_t dl    [2][LAT];
  out_t mo    [2];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input int exp);
    n_chk++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r,
                            input bit a,
                            input bit b);
    out_t o;
    bit   rise;
    bit   in_c;
    int   el;
    if (r) begin
      n = 0;
      for (int c = 0; c < 2; c++) begin
        armed[c] = 0;
        stl[c]   = 0;
        last[c]  = 0;
        tsm[c]   = 0;
        prv[c]   = 0;
        o = '{ts: 0, vld: 0, stale: 0};
        for (int i = 0; i < LAT; i++) dl[c][i] = o;
        mo[c] = o;
      end
    end else begin
      n++;
      for (int c = 0; c < 2; c++) begin
        in_c   = (c == 0) ? a : b;
        rise   = in_c && !prv[c];
        prv[c] = in_c;
        el     = n - last[c];
        o.vld  = 0;
        if (!armed[c]) begin
          if (rise) begin
            armed[c] = 1;
            last[c]  = n;
          end
        end else if (stl[c]) begin
          if (rise) begin
            stl[c]  = 0;
            last[c] = n;
          end
        end else if (rise && el >= MIN_P) begin
          tsm[c]  = el;
          o.vld   = 1;
          last[c] = n;
        end else if (el >= MAXV) begin
          tsm[c] = MAXV;
          o.vld  = 1;
          stl[c] = 1;
        end
        o.ts    = tsm[c];
        o.stale = stl[c];
        mo[c]   = dl[c][0];
        for (int i = 0; i < LAT - 1; i++)
          dl[c][i] = dl[c][i+1];
        dl[c][LAT-1] = o;
      end
    end
  endtask

  task automatic cycle(input bit r,
                       input bit a,
                       input bit b);
    rst = r;
    in1 = a;
    in2 = b;
    model_step(r, a, b);
    @(negedge clk);
    check("ts1",    32'(ts1),    mo[0].ts);
    check("vld1",   32'(vld1),   int'(mo[0].vld));
    check("stale1", 32'(stale1), int'(mo[0].stale));
    check("ts2",    32'(ts2),    mo[1].ts);
    check("vld2",   32'(vld2),   int'(mo[1].vld));
    check("stale2", 32'(stale2), int'(mo[1].stale));
  endtask

  task automatic run(input int ncyc,
                     input int p1,
                     input int p2);
    bit a;
    bit b;
    for (int i = 0; i < ncyc; i++) begin
      a = (p1 != 0) && (i % p1 == 0);
      b = (p2 != 0) && (i % p2 == 0);
      cycle(0, a, b);
    end
  endtask

  task automatic idle(input int ncyc);
    for (int i = 0; i < ncyc; i++) cycle(0, 0, 0);
  endtask

  function automatic bit pick(input int d);
    bit v;
    unique case (d)
      0:       v = ($urandom_range(0, 1) == 0);
      1:       v = ($urandom_range(0, 7) == 0);
      2:       v = ($urandom_range(0, 63) == 0);
      default: v = ($urandom_range(0, 399) == 0);
    endcase
    return v;
  endfunction

  initial begin
    int dens;
    bit r;
    n_chk  = 0;
    n_fail = 0;

    // Reset with toggling inputs
    cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(1, 0, 1);
    check("rst_ts1", 32'(ts1), 0);
    check("rst_stale2", 32'(stale2), 0);

    // Periodic channel 1
    run(120, 10, 0);
    check("per10_ts1", 32'(ts1), 10);

    // Channel 2 timeout, recovery, then 20-cycle period
    idle(2);
    cycle(0, 0, 1);
    idle(300);
    check("to_ts2", 32'(ts2), MAXV);
    check("to_stale2", 32'(stale2), 1);
    cycle(0, 0, 1);
    idle(LAT + 1);
    check("clr_stale2", 32'(stale2), 0);
    check("clr_ts2", 32'(ts2), MAXV);
    idle(20 - LAT - 2);
    cycle(0, 0, 1);
    idle(5);
    check("p20_ts2", 32'(ts2), 20);

    // Simultaneous periods 7 and 12
    run(200, 7, 12);
    check("sim_ts1", 32'(ts1), 7);
    check("sim_ts2", 32'(ts2), 12);

    // Glitch: rise 2 cycles after an accepted one is dropped
    idle(4);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    idle(13);
    cycle(0, 1, 0);
    idle(5);
    check("glitch_ts1", 32'(ts1), 16);

    // Reset mid-measurement
    cycle(0, 1, 0);
    idle(40);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("mid_ts1", 32'(ts1), 0);
    check("mid_ts2", 32'(ts2), 0);
    check("mid_stale1", 32'(stale1), 0);
    cycle(0, 1, 0);
    idle(LAT + 2);
    check("arm_only_ts1", 32'(ts1), 0);
    idle(8 - LAT - 2);
    cycle(0, 1, 0);
    idle(4);
    check("mid_p9_ts1", 32'(ts1), 9);

    // Random traffic with varying density and rare resets
    for (int s = 0; s < 8; s++) begin
      dens = $urandom_range(0, 3);
      for (int i = 0; i < 400; i++) begin
        r = ($urandom_range(0, 299) == 0);
        cycle(r, pick(dens), pick(dens));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
